// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seq_det_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  // Width needed to hold a pattern length of 0..max_len.
  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  // Out-of-range lengths are forced into 1..max_len.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Run-time programmable serial sequence detector with overlap control,
// a registered one-cycle match pulse and a saturating match tally.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned           MAX_LEN     = 8,
  parameter int unsigned           CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]    DEFAULT_PAT = 8'h0B,
  parameter int unsigned           DEFAULT_LEN = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic                           in_data,
  input  logic                           cfg_load,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  output logic                           out_data,
  output logic                           armed,
  output logic [CNT_W-1:0]               match_cnt
);

  localparam int unsigned          LEN_W   = len_width(MAX_LEN);
  localparam logic [LEN_W-1:0]     DEF_LEN = LEN_W'(clamp_len(DEFAULT_LEN, MAX_LEN));

  state_t               state_q, state_nx;
  logic [MAX_LEN-1:0]   pattern_q, pattern_nx;
  logic [LEN_W-1:0]     len_q, len_nx;
  logic                 overlap_q, overlap_nx;
  logic [MAX_LEN-1:0]   window_q, window_nx;
  logic [LEN_W-1:0]     fill_q, fill_nx;
  logic                 out_nx;

  logic [MAX_LEN-1:0]   next_window;
  logic [MAX_LEN-1:0]   mask;
  logic [LEN_W:0]       fill_inc;
  logic [LEN_W-1:0]     fill_sat;
  logic [LEN_W-1:0]     cfg_len_cl;
  logic                 hit;

  assign next_window = {window_q[MAX_LEN-2:0], in_data};
  assign fill_inc    = {1'b0, fill_q} + (LEN_W+1)'(1);
  assign fill_sat    = (fill_q == len_q) ? fill_q : fill_inc[LEN_W-1:0];
  assign cfg_len_cl  = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));

  // Only the low len bits take part in the comparison.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (i < 32'(len_q)) mask[i] = 1'b1;
    end
  end

  // A load in the same cycle discards the incoming bit, so it can never match.
  assign hit = in_valid && !cfg_load
            && (fill_inc >= {1'b0, len_q})
            && (((next_window ^ pattern_q) & mask) == '0);

  always_comb begin
    state_nx   = state_q;
    pattern_nx = pattern_q;
    len_nx     = len_q;
    overlap_nx = overlap_q;
    window_nx  = window_q;
    fill_nx    = fill_q;
    out_nx     = 1'b0;

    if (cfg_load) begin
      pattern_nx = cfg_pattern;
      len_nx     = cfg_len_cl;
      overlap_nx = cfg_overlap;
      window_nx  = '0;
      fill_nx    = '0;
      state_nx   = FILL;
    end else if (in_valid) begin
      window_nx = next_window;
      out_nx    = hit;
      case (state_q)
        FILL: begin
          if (hit && !overlap_q) begin
            fill_nx  = '0;
            state_nx = FILL;
          end else begin
            fill_nx  = fill_sat;
            state_nx = (fill_sat == len_q) ? ARMED : FILL;
          end
        end
        ARMED: begin
          if (hit && !overlap_q) begin
            fill_nx  = '0;
            state_nx = FILL;
          end else begin
            fill_nx  = fill_sat;
            state_nx = ARMED;
          end
        end
        default: begin
          fill_nx  = '0;
          state_nx = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FILL;
      pattern_q <= DEFAULT_PAT;
      len_q     <= DEF_LEN;
      overlap_q <= 1'b1;
      window_q  <= '0;
      fill_q    <= '0;
      out_data  <= 1'b0;
    end else begin
      state_q   <= state_nx;
      pattern_q <= pattern_nx;
      len_q     <= len_nx;
      overlap_q <= overlap_nx;
      window_q  <= window_nx;
      fill_q    <= fill_nx;
      out_data  <= out_nx;
    end
  end

  assign armed = (state_q == ARMED);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit),
    .clr   (cfg_load),
    .count (match_cnt)
  );

endmodule
